// File: rtl/data_memory_sized_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
// Optional alignment checking is enabled with the DMEM_ALIGN_CHECK_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    // Byte lanes touched by an access; halves/words are aligned down to their natural boundary.
    function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
interface data_memory_sized_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned;
    logic [31:0] fault_addr;
    logic        fault_clear;

    modport master (
        output MemRead, MemWrite, MemSize, MemSigned, address, write_data, fault_clear,
        input  read_data, read_valid, misaligned, fault_addr
    );

    modport slave (
        input  MemRead, MemWrite, MemSize, MemSigned, address, write_data, fault_clear,
        output read_data, read_valid, misaligned, fault_addr
    );
endinterface

// File: rtl/data_memory_sized_load_align.sv
// Combinational lane select plus sign/zero extension of a raw RAM word.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with 1- or 2-cycle pipelined loads.
// Define DMEM_ALIGN_CHECK_EN to enable sticky misalignment fault reporting.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int RAM_SIZE     = 512,
    parameter int RAM_SIZE_BIT = 9,
    parameter int READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    data_memory_sized_if.slave  bus
);

    logic [RAM_SIZE_BIT-1:0] word_idx;
    logic [1:0]              lane;
    mem_size_e               size;
    logic                    access_bad;
    logic                    write_en;
    logic                    read_en;
    logic [3:0]              lane_we;
    logic [31:0]             wdata_lanes;
    logic [31:0]             ram_q;

    assign word_idx = bus.address[RAM_SIZE_BIT+1:2];
    assign lane     = bus.address[1:0];
    assign size     = mem_size_e'(bus.MemSize);

`ifdef DMEM_ALIGN_CHECK_EN
    assign access_bad = is_misaligned(size, lane);
`else
    assign access_bad = 1'b0;
`endif

    assign write_en = bus.MemWrite && !reset && !access_bad;
    assign read_en  = bus.MemRead && !bus.MemWrite && !reset;
    assign lane_we  = write_en ? byte_enable(size, lane) : 4'b0000;

    // Store data is replicated so every enabled lane sees its own slice.
    always_comb begin
        case (size)
            SIZE_BYTE: wdata_lanes = {4{bus.write_data[7:0]}};
            SIZE_HALF: wdata_lanes = {2{bus.write_data[15:0]}};
            default:   wdata_lanes = bus.write_data;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [RAM_SIZE];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (lane_we[gi])
                    mem[word_idx] <= wdata_lanes[gi*8 +: 8];
                if (read_en)
                    q_reg <= mem[word_idx];
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // Load attributes travel alongside the RAM read; they hold between loads so read_data holds.
    logic       valid1_reg;
    logic       zero1_reg;
    logic [1:0] lane1_reg;
    mem_size_e  size1_reg;
    logic       signed1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_reg  <= 1'b0;
            zero1_reg   <= 1'b1;
            lane1_reg   <= 2'b00;
            size1_reg   <= SIZE_BYTE;
            signed1_reg <= 1'b0;
        end else begin
            valid1_reg <= read_en;
            if (read_en) begin
                zero1_reg   <= access_bad;
                lane1_reg   <= lane;
                size1_reg   <= size;
                signed1_reg <= bus.MemSigned;
            end
        end
    end

    logic [31:0] align_out;
    logic [31:0] aligned;

    dmem_load_align u_align (
        .word     (ram_q),
        .lane     (lane1_reg),
        .size     (size1_reg),
        .sign_ext (signed1_reg),
        .data     (align_out)
    );

    assign aligned = zero1_reg ? 32'h0 : align_out;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign bus.read_data  = aligned;
            assign bus.read_valid = valid1_reg;
        end else begin : g_lat2
            logic [31:0] read_data_reg;
            logic        read_valid_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    read_data_reg  <= 32'h0;
                    read_valid_reg <= 1'b0;
                end else begin
                    read_valid_reg <= valid1_reg;
                    if (valid1_reg)
                        read_data_reg <= aligned;
                end
            end

            assign bus.read_data  = read_data_reg;
            assign bus.read_valid = read_valid_reg;
        end
    endgenerate

`ifdef DMEM_ALIGN_CHECK_EN
    logic        misaligned_reg;
    logic [31:0] fault_addr_reg;
    logic        fault_now;

    assign fault_now = access_bad && (bus.MemRead || bus.MemWrite);

    // A new fault overrides a simultaneous clear; otherwise the first fault is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_reg <= 1'b0;
            fault_addr_reg <= 32'h0;
        end else if (fault_now && (!misaligned_reg || bus.fault_clear)) begin
            misaligned_reg <= 1'b1;
            fault_addr_reg <= bus.address;
        end else if (bus.fault_clear) begin
            misaligned_reg <= 1'b0;
            fault_addr_reg <= 32'h0;
        end
    end

    assign bus.misaligned = misaligned_reg;
    assign bus.fault_addr = fault_addr_reg;
`else
    logic unused_bits;
    assign unused_bits    = ^{bus.fault_clear, bus.address[31:RAM_SIZE_BIT+2]};
    assign bus.misaligned = 1'b0;
    assign bus.fault_addr = 32'h0;
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized scoreboard bench for data_memory_sized, running READ_LATENCY 1 and 2 side by side.
module tb_data_memory_sized;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_memory_sized_if bus1 ();
    data_memory_sized_if bus2 ();

    data_memory_sized #(.RAM_SIZE(512), .RAM_SIZE_BIT(9), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    data_memory_sized #(.RAM_SIZE(512), .RAM_SIZE_BIT(9), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp1 [$];
    logic [31:0] exp2 [$];

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Reference model: byte-addressed little-endian memory plus fault state.
    logic [7:0]  mem_m [2048];
    bit          fault_m = 1'b0;
    logic [31:0] fault_addr_m = 32'h0;

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (!CHECK_EN) return 1'b0;
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    task automatic model_step(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd, input bit fc);
        int n;
        int base;
        logic [31:0] val;
        bit bad;
        n    = size_bytes(sz);
        base = int'(a[10:0]) / n * n;
        bad  = model_misaligned(sz, a);
        if (wr) begin
            if (!bad)
                for (int i = 0; i < n; i++) mem_m[base + i] = wd[8*i +: 8];
        end else if (rd) begin
            val = 32'h0;
            if (!bad) begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = mem_m[base + i];
                if (n < 4 && sg && val[8*n-1])
                    for (int i = 8*n; i < 32; i++) val[i] = 1'b1;
            end
            exp1.push_back(val);
            exp2.push_back(val);
        end
        if ((rd || wr) && bad && (!fault_m || fc)) begin
            fault_m      = 1'b1;
            fault_addr_m = a;
        end else if (fc) begin
            fault_m      = 1'b0;
            fault_addr_m = 32'h0;
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit fc);
        bus1.MemRead = rd; bus1.MemWrite = wr; bus1.MemSize = sz; bus1.MemSigned = sg;
        bus1.address = a;  bus1.write_data = wd; bus1.fault_clear = fc;
        bus2.MemRead = rd; bus2.MemWrite = wr; bus2.MemSize = sz; bus2.MemSigned = sg;
        bus2.address = a;  bus2.write_data = wd; bus2.fault_clear = fc;
    endtask

    task automatic check_fault();
        logic [32:0] want;
        want = {fault_m, fault_addr_m};
        checks++;
        if ({bus1.misaligned, bus1.fault_addr} !== want) begin
            errors++;
            $display("FAIL fault_lat1 got %0b/%h expected %0b/%h",
                     bus1.misaligned, bus1.fault_addr, want[32], want[31:0]);
        end
        checks++;
        if ({bus2.misaligned, bus2.fault_addr} !== want) begin
            errors++;
            $display("FAIL fault_lat2 got %0b/%h expected %0b/%h",
                     bus2.misaligned, bus2.fault_addr, want[32], want[31:0]);
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit fc);
        $display("op rd=%0d wr=%0d size=%0d signed=%0d addr=%h wdata=%h clr=%0d",
                 rd, wr, sz, sg, a, wd, fc);
        drive(rd, wr, sz, sg, a, wd, fc);
        model_step(rd, wr, sz, sg, a, wd, fc);
        @(posedge clk);
        #1;
        check_fault();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Applies reset for one edge with the given request presented, then checks outputs are cleared.
    task automatic reset_with(input bit rd, input logic [31:0] a);
        $display("reset with rd=%0d addr=%h", rd, a);
        drive(rd, 1'b0, 2'd2, 1'b0, a, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp1.delete();
        exp2.delete();
        fault_m      = 1'b0;
        fault_addr_m = 32'h0;
        checks++;
        if ({bus1.read_valid, bus1.read_data, bus1.misaligned, bus1.fault_addr} !== 66'h0) begin
            errors++;
            $display("FAIL reset_lat1 got v=%0b d=%h m=%0b f=%h expected all zero",
                     bus1.read_valid, bus1.read_data, bus1.misaligned, bus1.fault_addr);
        end
        checks++;
        if ({bus2.read_valid, bus2.read_data, bus2.misaligned, bus2.fault_addr} !== 66'h0) begin
            errors++;
            $display("FAIL reset_lat2 got v=%0b d=%h m=%0b f=%h expected all zero",
                     bus2.read_valid, bus2.read_data, bus2.misaligned, bus2.fault_addr);
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: every read_valid pops and compares the oldest expected load.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && bus1.read_valid) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL lat1_valid got unexpected read_valid data=%h expected none", bus1.read_data);
            end else begin
                e = exp1.pop_front();
                $display("rd lat1 data=%h expected=%h", bus1.read_data, e);
                if (bus1.read_data !== e) begin
                    errors++;
                    $display("FAIL lat1_data got %h expected %h", bus1.read_data, e);
                end
            end
        end
        if (!reset && bus2.read_valid) begin
            checks++;
            if (exp2.size() == 0) begin
                errors++;
                $display("FAIL lat2_valid got unexpected read_valid data=%h expected none", bus2.read_data);
            end else begin
                e = exp2.pop_front();
                $display("rd lat2 data=%h expected=%h", bus2.read_data, e);
                if (bus2.read_data !== e) begin
                    errors++;
                    $display("FAIL lat2_data got %h expected %h", bus2.read_data, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd;
        bit          wr;
        int          wait_cycles;

        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_with(1'b0, 32'h0);

        // Known contents for the low 256 bytes so random loads read defined data.
        for (int i = 0; i < 64; i++)
            issue(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0);

        // Directed scenarios.
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, 1'b0);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, 1'b0);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h5, 1'b0);
        idle(3);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h52, 32'h11223344, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFF_F844, 32'h0, 1'b0);
        idle(3);

        // Back-to-back loads with reset arriving while the third is presented.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
        reset_with(1'b1, 32'h18);
        idle(4);

        // Randomized traffic with aliased upper address bits.
        for (int n = 0; n < 300; n++) begin
            a  = {$urandom_range(0, 2097151), 3'b000, 8'($urandom)};
            sz = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 3) == 0);
            issue(rd, wr, sz, 1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0));
            if (n == 150) reset_with(1'b1, a);
        end

        wait_cycles = 0;
        while ((exp1.size() != 0 || exp2.size() != 0) && wait_cycles < 10) begin
            idle(1);
            wait_cycles++;
        end
        @(negedge clk);
        checks++;
        if (exp1.size() != 0 || exp2.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d loads outstanding expected 0/0", exp1.size(), exp2.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
